// File: rtl/led_pkg.sv
// Shared LED command definitions: opcodes and command-word field layout.
package led_pkg;

  // Command word is {address, opcode, data}, 12 bits wide.
  localparam int CMD_W    = 12;
  localparam int ADDR_MSB = 11;
  localparam int ADDR_LSB = 7;
  localparam int OP_MSB   = 6;
  localparam int OP_LSB   = 4;
  localparam int D_MSB    = 3;
  localparam int D_LSB    = 0;

  typedef enum logic [2:0] {
    CMD_NOP = 3'b000,
    CMD_TGL = 3'b001,
    CMD_SHL = 3'b010,
    CMD_SHR = 3'b011,
    CMD_OFF = 3'b100,
    CMD_ON  = 3'b101,
    CMD_RST = 3'b110,
    CMD_SET = 3'b111
  } cmd_op_e;

endpackage

// File: rtl/led_blink_timer.sv
// Blink phase generator: prescaler -> tick counter -> phase flip-flop.
// Phase resets to 1 (LEDs shown) and is frozen at 1 while rate is 0.
module led_blink_timer
  import led_pkg::*;
#(
  parameter int BLINK_HALF = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rate_wr,
  input  logic [3:0] rate_in,
  output logic       phase
);

  localparam int PW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(BLINK_HALF - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    tick_q, tick_d;
  logic [3:0]    rate_q, rate_d;
  logic          phase_q, phase_d;

  // Next-state: a rate write restarts the timing, overriding any tick that would fire now.
  always_comb begin
    pre_d   = pre_q;
    tick_d  = tick_q;
    rate_d  = rate_q;
    phase_d = phase_q;
    if (rate_wr) begin
      rate_d  = rate_in;
      pre_d   = '0;
      tick_d  = '0;
      phase_d = 1'b1;
    end else if (rate_q == 4'd0) begin
      pre_d   = '0;
      tick_d  = '0;
      phase_d = 1'b1;
    end else if (pre_q == PRE_LAST) begin
      pre_d = '0;
      if (tick_q == rate_q - 4'd1) begin
        tick_d  = '0;
        phase_d = ~phase_q;
      end else begin
        tick_d = tick_q + 4'd1;
      end
    end else begin
      pre_d = pre_q + PW'(1);
    end
  end

  // Timer registers with synchronous reset to a rate of one tick per phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q   <= '0;
      tick_q  <= '0;
      rate_q  <= 4'd1;
      phase_q <= 1'b1;
    end else begin
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      rate_q  <= rate_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/led_array_ctrl.sv
// LED array controller: decodes bus commands into a state plane and a
// blink plane, and masks blinking LEDs off during the low blink phase.
module led_array_ctrl
  import led_pkg::*;
#(
  parameter logic [4:0] DEV_ADDR   = 5'h0C,
  parameter logic [4:0] BLINK_ADDR = 5'h0D,
  parameter int         N_LEDS     = 10,
  parameter int         BLINK_HALF = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              new_cmd,
  input  logic [CMD_W-1:0]  cmd_buf,
  output logic [N_LEDS-1:0] leds,
  output logic              ack
);

  localparam logic [N_LEDS-1:0] ONE = N_LEDS'(1);

  logic [4:0]        cmdAddr;
  cmd_op_e           cmdOp;
  logic [3:0]        cmdD;
  logic [N_LEDS-1:0] mask;
  logic              hitDev, hitBlink, rateWr, phase;

  logic [N_LEDS-1:0] state_q, state_d;
  logic [N_LEDS-1:0] blink_q, blink_d;
  logic              ack_q, ack_d;

  assign cmdAddr  = cmd_buf[ADDR_MSB:ADDR_LSB];
  assign cmdOp    = cmd_op_e'(cmd_buf[OP_MSB:OP_LSB]);
  assign cmdD     = cmd_buf[D_MSB:D_LSB];
  assign hitDev   = new_cmd && (cmdAddr == DEV_ADDR);
  assign hitBlink = new_cmd && (cmdAddr == BLINK_ADDR);
  assign rateWr   = hitBlink && (cmdOp == CMD_NOP);

  // Shifting past the top bit leaves an all-zero mask, so out-of-range indices do nothing.
  assign mask = ONE << cmdD;

  // Applies one opcode to a plane; NOP leaves the plane alone (rate writes are handled by the timer).
  function automatic logic [N_LEDS-1:0] applyOp(
    input logic [N_LEDS-1:0] p,
    input cmd_op_e           op,
    input logic [3:0]        d,
    input logic [N_LEDS-1:0] m
  );
    logic [N_LEDS-1:0] r;
    r = p;
    case (op)
      CMD_OFF: r = p & ~m;
      CMD_ON:  r = p | m;
      CMD_TGL: r = p ^ m;
      CMD_RST: r = '0;
      CMD_SET: r = '1;
      CMD_SHL: begin
        r    = p << 1;
        r[0] = d[3] ? p[N_LEDS-1] : d[0];
      end
      CMD_SHR: begin
        r           = p >> 1;
        r[N_LEDS-1] = d[3] ? p[0] : d[0];
      end
      default: r = p;
    endcase
    return r;
  endfunction

  // Next-state for both planes and the acknowledge pulse.
  always_comb begin
    state_d = state_q;
    blink_d = blink_q;
    ack_d   = hitDev || hitBlink;
    if (hitDev) begin
      state_d = applyOp(state_q, cmdOp, cmdD, mask);
    end
    if (hitBlink) begin
      blink_d = applyOp(blink_q, cmdOp, cmdD, mask);
    end
  end

  // Plane and ack registers; reset wins over any command presented on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
      blink_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      blink_q <= blink_d;
      ack_q   <= ack_d;
    end
  end

  led_blink_timer #(
    .BLINK_HALF(BLINK_HALF)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .rate_wr(rateWr),
    .rate_in(cmdD),
    .phase  (phase)
  );

  assign leds = state_q & ~(blink_q & {N_LEDS{~phase}});
  assign ack  = ack_q;

endmodule
